// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler: shares one streaming FIR kernel between NCH channel streams using
// round-robin burst grants, routes kernel results back to the granted channel, and flags stalls.
module fir_channel_scheduler #(
    parameter int  NCH     = 4,
    parameter int  DW      = 16,
    parameter int  BURST   = 8,
    parameter int  TIMEOUT = 1024,
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [NCH*DW-1:0] s_axis_tdata,
    input  logic [NCH-1:0]    s_axis_tvalid,
    output logic [NCH-1:0]    s_axis_tready,
    output logic [DW-1:0]     k_in_tdata,
    output logic              k_in_tvalid,
    input  logic              k_in_tready,
    input  logic [DW-1:0]     k_out_tdata,
    input  logic              k_out_tvalid,
    output logic              k_out_tready,
    output logic [NCH*DW-1:0] m_axis_tdata,
    output logic [NCH-1:0]    m_axis_tvalid,
    input  logic [NCH-1:0]    m_axis_tready,
    output logic [CW-1:0]     cur_chan,
    output logic              busy,
    output logic              stall_flag
);
    localparam int CNTW = $clog2(BURST + 1);
    localparam int WDW  = $clog2(TIMEOUT + 1);

    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] BURST_C  = CNTW'(BURST);
    localparam logic [CNTW-1:0] BURST_M1 = CNTW'(BURST - 1);
    localparam logic [WDW-1:0]  WD_ONE   = WDW'(1);
    localparam logic [WDW-1:0]  WD_MAX   = WDW'(TIMEOUT);
    localparam logic [WDW-1:0]  WD_TRIP  = WDW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   LAST_CH  = CW'(NCH - 1);
    localparam logic [CW:0]     NCH_W    = (CW + 1)'(NCH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CNTW-1:0] sent_r;
    logic [CNTW-1:0] rcvd_r;
    logic [CW-1:0]   last_grant_r;
    logic [CW-1:0]   cur_chan_r;
    logic [WDW-1:0]  wdog_r;
    logic            stall_flag_r;

    logic            grant_hit_s;
    logic [CW-1:0]   grant_idx_s;
    logic [CW:0]     cand_sum_s;
    logic [CW-1:0]   cand_idx_s;
    logic            in_hs_s;
    logic            out_hs_s;
    logic            drain_done_s;

    assign in_hs_s      = k_in_tvalid & k_in_tready;
    assign out_hs_s     = k_out_tvalid & k_out_tready;
    assign drain_done_s = (rcvd_r == BURST_C) | (out_hs_s & (rcvd_r == BURST_M1));

    assign k_in_tdata    = s_axis_tdata[cur_chan_r*DW +: DW];
    assign m_axis_tdata  = {NCH{k_out_tdata}};
    assign cur_chan      = cur_chan_r;
    assign busy          = (state_r != IDLE);
    assign stall_flag    = stall_flag_r;

    // Round-robin search from last_grant+1; walking backwards lets the nearest hit win.
    always_comb begin
        grant_hit_s = 1'b0;
        grant_idx_s = '0;
        cand_sum_s  = '0;
        cand_idx_s  = '0;
        for (int k = NCH; k >= 1; k--) begin
            cand_sum_s  = {1'b0, last_grant_r} + (CW + 1)'(k);
            cand_sum_s  = (cand_sum_s >= NCH_W) ? (cand_sum_s - NCH_W) : cand_sum_s;
            cand_idx_s  = cand_sum_s[CW-1:0];
            grant_idx_s = s_axis_tvalid[cand_idx_s] ? cand_idx_s : grant_idx_s;
            grant_hit_s = grant_hit_s | s_axis_tvalid[cand_idx_s];
        end
    end

    // State register.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode: a grant is held until the whole burst has gone out and come back.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_hit_s) state_nxt_s = SEND;
                else             state_nxt_s = IDLE;
            end
            SEND: begin
                if (in_hs_s && (sent_r == BURST_M1)) state_nxt_s = DRAIN;
                else                                 state_nxt_s = SEND;
            end
            DRAIN: begin
                if (drain_done_s) state_nxt_s = IDLE;
                else              state_nxt_s = DRAIN;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Handshake steering: only the granted lane sees the kernel, everything is idle otherwise.
    always_comb begin
        s_axis_tready = '0;
        m_axis_tvalid = '0;
        k_in_tvalid   = 1'b0;
        k_out_tready  = 1'b0;
        case (state_r)
            SEND: begin
                k_in_tvalid               = s_axis_tvalid[cur_chan_r];
                s_axis_tready[cur_chan_r] = k_in_tready;
                m_axis_tvalid[cur_chan_r] = k_out_tvalid;
                k_out_tready              = m_axis_tready[cur_chan_r];
            end
            DRAIN: begin
                m_axis_tvalid[cur_chan_r] = k_out_tvalid;
                k_out_tready              = m_axis_tready[cur_chan_r];
            end
            default: begin
                k_in_tvalid  = 1'b0;
                k_out_tready = 1'b0;
            end
        endcase
    end

    // Grant bookkeeping and saturating burst counters.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            sent_r       <= '0;
            rcvd_r       <= '0;
            last_grant_r <= LAST_CH;
            cur_chan_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    sent_r <= '0;
                    rcvd_r <= '0;
                    if (grant_hit_s) begin
                        cur_chan_r   <= grant_idx_s;
                        last_grant_r <= grant_idx_s;
                    end
                end
                SEND: begin
                    if (in_hs_s && (sent_r == BURST_M1)) sent_r <= '0;
                    else if (in_hs_s && (sent_r != BURST_C)) sent_r <= sent_r + CNT_ONE;
                    if (out_hs_s && (rcvd_r != BURST_C)) rcvd_r <= rcvd_r + CNT_ONE;
                end
                DRAIN: begin
                    if (drain_done_s) rcvd_r <= '0;
                    else if (out_hs_s) rcvd_r <= rcvd_r + CNT_ONE;
                end
                default: begin
                    sent_r <= '0;
                    rcvd_r <= '0;
                end
            endcase
        end
    end

    // Stall watchdog: counts consecutive granted cycles without any kernel handshake.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            wdog_r       <= '0;
            stall_flag_r <= 1'b0;
        end else if ((state_r == IDLE) || in_hs_s || out_hs_s) begin
            wdog_r <= '0;
        end else begin
            if (wdog_r == WD_TRIP) stall_flag_r <= 1'b1;
            if (wdog_r != WD_MAX)  wdog_r <= wdog_r + WD_ONE;
        end
    end

endmodule
